muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the Execute-stage ALU and is launched from EX with already-forwarded operands.
- Holds `busy` so the hazard unit can stall dependent MFHI/MFLO and further mul/div ops.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO, which the current single-cycle ALU path lacks.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/mdu_iter_core.sv | 41 ++++
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_t    - 3-bit operation code presented on the request bus
//   mdu_state_t - sequencer states (IDLE, CALC, FIX)
//   mdu_wide_t  - wide scratch type used by the sign helpers; it is wide
//                 enough for a full 2*WIDTH product when WIDTH <= MDU_MAX_WIDTH
//   abs_s       - magnitude of a sign-extended operand when the op is signed
//   neg_if      - two's-complement negate when flag is set
package mdu_pkg;

  localparam int MDU_MAX_WIDTH = 64;

  typedef logic [2*MDU_MAX_WIDTH-1:0] mdu_wide_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_t;

  // The caller sign-extends the operand into the wide type, so the top bit
  // of the wide value is the operand's sign.
  function automatic mdu_wide_t abs_s(input mdu_wide_t value, input logic is_signed);
    return (is_signed && value[2*MDU_MAX_WIDTH-1]) ? -value : value;
  endfunction

  // Negation commutes with truncation, so the low bits of the wide result
  // are the correct narrow result for any operand width.
  function automatic mdu_wide_t neg_if(input mdu_wide_t value, input logic flag);
    return flag ? -value : value;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bus between the Execute stage and the
// multiply/divide unit.
//   start, op, srca, srcb, cancel - driven by the EX stage (master)
//   busy, done, hi, lo            - driven by the unit (slave)
interface muldiv_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one iteration of the multiply/divide datapath (combinational).
//   isDiv_i  - 1: restoring shift-subtract step, 0: shift-add step
//   accHi_i  - multiply: running upper product / divide: partial remainder
//   accLo_i  - multiply: remaining multiplier bits / divide: dividend bits
//              shifting out while quotient bits shift in
//   opnd_i   - multiplicand (multiply) or divisor (divide)
//   accHi_o, accLo_o - accumulator values after this step
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] accHi_i,
  input  logic [WIDTH-1:0] accLo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] accHi_o,
  output logic [WIDTH-1:0] accLo_o
);

  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] divShifted;
  logic           divFits;

  always_comb begin
    mulSum     = {1'b0, accHi_i} + (accLo_i[0] ? {1'b0, opnd_i} : '0);
    divShifted = {accHi_i, accLo_i[WIDTH-1]};
    divFits    = (divShifted >= {1'b0, opnd_i});
    accHi_o    = '0;
    accLo_o    = '0;
    if (isDiv_i) begin
      // A zero divisor always "fits", so the dividend ends up in the
      // remainder and the quotient becomes all ones.
      accHi_o = divFits ? WIDTH'(divShifted - {1'b0, opnd_i}) : divShifted[WIDTH-1:0];
      accLo_o = {accLo_i[WIDTH-2:0], divFits};
    end else begin
      // The carry of the add shifts into the top of the product.
      accHi_o = mulSum[WIDTH:1];
      accLo_o = {mulSum[0], accLo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit holding the
// architectural HI/LO registers.
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   bus   - muldiv_unit_if.slave: start/op/srca/srcb/cancel in,
//           busy/done/hi/lo out
// Signed operations run on magnitudes; the FIX state re-applies the signs.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  muldiv_unit_if.slave bus
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  mdu_state_t       state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] accHi_q, accLo_q, opnd_q;
  logic [WIDTH-1:0] accHi_d, accLo_d;
  logic             isDiv_q, signA_q, signB_q, bZero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             isSigned, isDivOp;
  mdu_wide_t        aExt, bExt;
  logic [WIDTH-1:0] absA, absB;
  mdu_wide_t        fixProd;
  logic [WIDTH-1:0] fixQuot, fixRem;

  // Operand preparation for the accept edge and sign fix-up for FIX exit.
  always_comb begin
    isSigned = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    isDivOp  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    aExt     = {{(2*MDU_MAX_WIDTH-WIDTH){isSigned & bus.srca[WIDTH-1]}}, bus.srca};
    bExt     = {{(2*MDU_MAX_WIDTH-WIDTH){isSigned & bus.srcb[WIDTH-1]}}, bus.srcb};
    absA     = WIDTH'(abs_s(aExt, isSigned));
    absB     = WIDTH'(abs_s(bExt, isSigned));
    fixProd  = neg_if(mdu_wide_t'({accHi_q, accLo_q}), signA_q ^ signB_q);
    // A zero divisor must read back as all ones whatever the dividend sign.
    fixQuot  = bZero_q ? '1 : WIDTH'(neg_if(mdu_wide_t'(accLo_q), signA_q ^ signB_q));
    fixRem   = WIDTH'(neg_if(mdu_wide_t'(accHi_q), signA_q));
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .isDiv_i (isDiv_q),
    .accHi_i (accHi_q),
    .accLo_i (accLo_q),
    .opnd_i  (opnd_q),
    .accHi_o (accHi_d),
    .accLo_o (accLo_d)
  );

  // Sequencer, iteration counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
      opnd_q  <= '0;
      isDiv_q <= 1'b0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      bZero_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.op)
              OP_MTHI: begin
                hi_q   <= bus.srca;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.srca;
                done_q <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q <= CALC;
                cnt_q   <= '0;
                isDiv_q <= isDivOp;
                signA_q <= isSigned & bus.srca[WIDTH-1];
                signB_q <= isSigned & bus.srcb[WIDTH-1];
                bZero_q <= (bus.srcb == '0);
                accHi_q <= '0;
                accLo_q <= isDivOp ? absA : absB;
                opnd_q  <= isDivOp ? absB : absA;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state_q <= IDLE;
          end else begin
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (isDiv_q) begin
              hi_q <= fixRem;
              lo_q <= fixQuot;
            end else begin
              hi_q <= WIDTH'(fixProd >> WIDTH);
              lo_q <= WIDTH'(fixProd);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, self-checking bench for muldiv_unit at WIDTH=32.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one request for a single cycle; returns at the falling edge
  // right after the accept edge.
  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Issue a request and count how many sampled cycles busy stays high.
  task automatic runOp(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic dn);
    issue(o, a, b);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    dn = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo); end
  endtask

  task automatic test_mtlo();
    issue(OP_MTLO, 32'hCAFEBABE, 32'h0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.lo !== 32'hCAFEBABE) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected cafebabe", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL mtlo_hi: got %h expected 00000000", bus.hi); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_start_cancel_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MTHI; bus.srca = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL sc_idle_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL sc_idle_hi: got %h expected 00000000", bus.hi); end
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULT; bus.srca = 32'd2; bus.srcb = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sc_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_nop();
    issue(OP_NOP6, 32'h11111111, 32'h22222222);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL nop_done: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL nop_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.lo !== 32'hCAFEBABE) begin errors++; $display("[TB] FAIL nop_lo: got %h expected cafebabe", bus.lo); end
  endtask

  task automatic test_mult();
    int cyc; logic dn;
    runOp(OP_MULT, 32'hFFFFFFFD, 32'h00000005, cyc, dn);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 33", cyc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL mult_done: got %b expected 1", dn); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffff1", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_multu();
    int cyc; logic dn;
    runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, dn);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", cyc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL multu_done: got %b expected 1", dn); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int cyc; logic dn;
    runOp(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cyc, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL div_neg_done: got %b expected 1", dn); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", bus.hi); end
    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, dn);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", bus.hi); end
    runOp(OP_DIV, 32'h00000007, 32'hFFFFFFFE, cyc, dn);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_negb_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("[TB] FAIL div_negb_hi: got %h expected 00000001", bus.hi); end
    runOp(OP_DIVU, 32'd100, 32'd7, cyc, dn);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divu_busy_cycles: got %0d expected 33", cyc); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h expected 00000002", bus.hi); end
  endtask

  task automatic test_div_zero();
    int cyc; logic dn;
    runOp(OP_DIVU, 32'h0000000A, 32'h00000000, cyc, dn);
    checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL divu0_done: got %b expected 1", dn); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu0_lo: got %h expected ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h0000000A) begin errors++; $display("[TB] FAIL divu0_hi: got %h expected 0000000a", bus.hi); end
    runOp(OP_DIV, 32'hFFFFFFF9, 32'h00000000, cyc, dn);
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div0_lo: got %h expected ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFF9) begin errors++; $display("[TB] FAIL div0_hi: got %h expected fffffff9", bus.hi); end
  endtask

  task automatic test_cancel();
    int cyc; logic dn;
    runOp(OP_MTHI, 32'h12345678, 32'h0, cyc, dn);
    runOp(OP_MTLO, 32'h0BADF00D, 32'h0, cyc, dn);
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", bus.hi); end
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_done: got %b expected 0", bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_done_late: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL cancel_hi: got %h expected 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL cancel_lo: got %h expected 0badf00d", bus.lo); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    issue(OP_MULTU, 32'd4, 32'd5);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = OP_MTHI; bus.srca = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL swb_busy_cycles: got %0d expected 33", cyc); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL swb_done: got %b expected 1", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL swb_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd20) begin errors++; $display("[TB] FAIL swb_lo: got %h expected 00000014", bus.lo); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL swb_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic doneSeen;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_lo: got %h expected 00000000", bus.lo); end
    doneSeen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen = 1'b1;
    end
    checks++; if (doneSeen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %b expected 0", doneSeen); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_lo_late: got %h expected 00000000", bus.lo); end
  endtask

  // Test sequence.
  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = OP_MULT;
    bus.srca   = 32'h0;
    bus.srcb   = 32'h0;
    $display("[TB] muldiv_unit bench starting");
    test_reset();
    test_mtlo();
    test_start_cancel_idle();
    test_nop();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_cancel();
    test_start_while_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
